branch_tag_allocator: RTL and testbench

- Owns the BS_SIZE branch-stack checkpoint slots.
- Hands a one-hot branch tag to each dispatching branch and drives the checkpoint write strobe and slot mask into the branch RAT checkpoint array.
- Tracks older/younger dependencies between live slots. Frees slots on correct resolution and bulk-frees the mispredicted slot plus all younger slots on a squash.
- Supplies dispatch with the dependency mask that tags new instructions, and a stall when no slot is free.

---
 rtl/branch_tag_allocator.sv | 140 ++++++++++++++
 tb/tb_branch_tag_allocator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/branch_tag_allocator.sv
// Branch-stack tag allocator: hands one-hot checkpoint tags to dispatching
// branches, tracks older/younger dependencies between live slots, frees on
// correct resolve and bulk-frees the squashed subtree on a mispredict.
// Optional build macro: BRAT_ALLOC_STATS_EN adds stall/squash statistics counters.
module branch_tag_allocator #(
  parameter int unsigned BS_SIZE = 4,
  parameter int unsigned CNT_W   = $clog2(BS_SIZE + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alloc_req,
  output logic               alloc_grant,
  output logic               checkpoint_write,
  output logic [BS_SIZE-1:0] checkpoint_mask,
  output logic [BS_SIZE-1:0] cur_dep_mask,
  input  logic               resolve_valid,
  input  logic [BS_SIZE-1:0] resolve_mask,
  input  logic               resolve_mispredict,
  output logic [BS_SIZE-1:0] squash_mask,
  output logic               stall,
  output logic [CNT_W-1:0]   free_count
`ifdef BRAT_ALLOC_STATS_EN
  ,
  output logic [31:0]        stat_stall_cycles,
  output logic [31:0]        stat_squashes,
  output logic [31:0]        stat_slots_squashed
`endif
);

  logic [BS_SIZE-1:0] busy_q, busy_d;
  logic [BS_SIZE-1:0] dep_q [BS_SIZE];
  logic [BS_SIZE-1:0] dep_d [BS_SIZE];

  logic               res_onehot;
  logic               res_valid;
  logic               mispredict_v;
  logic               correct_v;
  logic [BS_SIZE-1:0] clr_mask;
  logic [BS_SIZE-1:0] cand_oh;
  logic               cand_found;

  // Qualify the resolve: one-hot and pointing at a live slot, otherwise ignored.
  always_comb begin
    res_onehot   = (resolve_mask != '0) &&
                   ((resolve_mask & (resolve_mask - BS_SIZE'(1))) == '0);
    res_valid    = resolve_valid & res_onehot & (|(resolve_mask & busy_q));
    mispredict_v = res_valid & resolve_mispredict;
    correct_v    = res_valid & ~resolve_mispredict;
    clr_mask     = correct_v ? resolve_mask : '0;
  end

  // Lowest-index free slot in registered state (a slot freed this cycle is not a candidate).
  always_comb begin
    cand_oh    = '0;
    cand_found = 1'b0;
    for (int i = 0; i < BS_SIZE; i++) begin
      if (!busy_q[i] && !cand_found) begin
        cand_oh[i] = 1'b1;
        cand_found = 1'b1;
      end
    end
  end

  // Squash set: the mispredicted slot plus every live slot that depends on it.
  always_comb begin
    squash_mask = '0;
    for (int j = 0; j < BS_SIZE; j++) begin
      squash_mask[j] = mispredict_v &
                       (resolve_mask[j] | (busy_q[j] & (|(dep_q[j] & resolve_mask))));
    end
  end

  // Grant and status outputs; a squash blocks the wrong-path branch from allocating.
  always_comb begin
    stall            = &busy_q;
    alloc_grant      = alloc_req & ~stall & ~mispredict_v;
    checkpoint_write = alloc_grant;
    checkpoint_mask  = alloc_grant ? cand_oh : '0;
    cur_dep_mask     = busy_q;
    free_count       = '0;
    for (int i = 0; i < BS_SIZE; i++) begin
      free_count = free_count + CNT_W'(!busy_q[i]);
    end
  end

  // Next busy/dependency state from resolve, squash and grant.
  always_comb begin
    busy_d = (busy_q & ~clr_mask & ~squash_mask) | (alloc_grant ? cand_oh : '0);
    for (int j = 0; j < BS_SIZE; j++) begin
      dep_d[j] = dep_q[j] & ~clr_mask;
      if (clr_mask[j] || squash_mask[j]) begin
        dep_d[j] = '0;
      end
      if (alloc_grant && cand_oh[j]) begin
        dep_d[j] = busy_q & ~clr_mask;
      end
    end
  end

  // Slot state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      for (int j = 0; j < BS_SIZE; j++) begin
        dep_q[j] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int j = 0; j < BS_SIZE; j++) begin
        dep_q[j] <= dep_d[j];
      end
    end
  end

`ifdef BRAT_ALLOC_STATS_EN
  logic [31:0] sq_pop;

  // Number of slots killed this cycle.
  always_comb begin
    sq_pop = '0;
    for (int i = 0; i < BS_SIZE; i++) begin
      sq_pop = sq_pop + 32'(squash_mask[i]);
    end
  end

  // Free-running statistics counters, wrapping at 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_stall_cycles   <= '0;
      stat_squashes       <= '0;
      stat_slots_squashed <= '0;
    end else begin
      if (alloc_req && stall) stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (mispredict_v)       stat_squashes     <= stat_squashes + 32'd1;
      stat_slots_squashed <= stat_slots_squashed + sq_pop;
    end
  end
`endif

endmodule

// File: tb/tb_branch_tag_allocator.sv
// Scoreboard bench for branch_tag_allocator: the driver pushes hand-computed
// expected outputs per cycle, a negedge monitor pops and compares them.
module tb_branch_tag_allocator;

  logic       clock;
  logic       reset;
  logic       alloc_req;
  logic       alloc_grant;
  logic       checkpoint_write;
  logic [3:0] checkpoint_mask;
  logic [3:0] cur_dep_mask;
  logic       resolve_valid;
  logic [3:0] resolve_mask;
  logic       resolve_mispredict;
  logic [3:0] squash_mask;
  logic       stall;
  logic [2:0] free_count;
`ifdef BRAT_ALLOC_STATS_EN
  logic [31:0] stat_stall_cycles, stat_squashes, stat_slots_squashed;
`endif

  branch_tag_allocator dut (
    .clock             (clock),
    .reset             (reset),
    .alloc_req         (alloc_req),
    .alloc_grant       (alloc_grant),
    .checkpoint_write  (checkpoint_write),
    .checkpoint_mask   (checkpoint_mask),
    .cur_dep_mask      (cur_dep_mask),
    .resolve_valid     (resolve_valid),
    .resolve_mask      (resolve_mask),
    .resolve_mispredict(resolve_mispredict),
    .squash_mask       (squash_mask),
    .stall             (stall),
    .free_count        (free_count)
`ifdef BRAT_ALLOC_STATS_EN
    ,
    .stat_stall_cycles  (stat_stall_cycles),
    .stat_squashes      (stat_squashes),
    .stat_slots_squashed(stat_slots_squashed)
`endif
  );

  typedef struct {
    int         id;
    logic       g;
    logic [3:0] cm;
    logic [3:0] sq;
    logic [3:0] dep;
    logic       st;
    int         fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, id, act, req);
    end
  endtask

  // Monitor: compare whatever the driver queued for this cycle, mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("alloc_grant",      e.id, int'(alloc_grant),      int'(e.g));
      chk("checkpoint_write", e.id, int'(checkpoint_write), int'(e.g));
      chk("checkpoint_mask",  e.id, int'(checkpoint_mask),  int'(e.cm));
      chk("squash_mask",      e.id, int'(squash_mask),      int'(e.sq));
      chk("cur_dep_mask",     e.id, int'(cur_dep_mask),     int'(e.dep));
      chk("stall",            e.id, int'(stall),            int'(e.st));
      chk("free_count",       e.id, int'(free_count),       e.fc);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic cyc(input bit req, input bit rv, input bit [3:0] rm, input bit mp,
                     input bit g, input bit [3:0] cm, input bit [3:0] sq,
                     input bit [3:0] dep, input bit st, input int fc);
    exp_t e;
    alloc_req          = req;
    resolve_valid      = rv;
    resolve_mask       = rm;
    resolve_mispredict = mp;
    vec_id++;
    e.id = vec_id; e.g = g; e.cm = cm; e.sq = sq; e.dep = dep; e.st = st; e.fc = fc;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; alloc_req = 1'b0; resolve_valid = 1'b0;
    resolve_mask = 4'b0; resolve_mispredict = 1'b0;
    @(posedge clock); #1;
    //  req rv rm      mp  g  cm      sq      dep     st fc
    cyc(0,  0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4);  // in reset
    reset = 1'b1;
    // fill in order
    cyc(1,  0, 4'b0000, 0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 4);
    cyc(1,  0, 4'b0000, 0, 1, 4'b0010, 4'b0000, 4'b0001, 0, 3);
    cyc(1,  0, 4'b0000, 0, 1, 4'b0100, 4'b0000, 4'b0011, 0, 2);
    cyc(1,  0, 4'b0000, 0, 1, 4'b1000, 4'b0000, 4'b0111, 0, 1);
    // full: request refused, then correct resolve of slot 1 and re-grant
    cyc(1,  0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b1111, 1, 0);
    cyc(0,  1, 4'b0010, 0, 0, 4'b0000, 4'b0000, 4'b1111, 1, 0);
    cyc(1,  0, 4'b0000, 0, 1, 4'b0010, 4'b0000, 4'b1101, 0, 1);
    // new slot 1 is youngest: its mispredict kills only itself
    cyc(0,  1, 4'b0010, 1, 0, 4'b0000, 4'b0010, 4'b1111, 1, 0);
    // reset mid-operation: no squash pulse, everything freed
    reset = 1'b0;
    cyc(0,  1, 4'b0001, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4);
    reset = 1'b1;
    // refill, then mispredict slot 1 kills 1..3
    cyc(1,  0, 4'b0000, 0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 4);
    cyc(1,  0, 4'b0000, 0, 1, 4'b0010, 4'b0000, 4'b0001, 0, 3);
    cyc(1,  0, 4'b0000, 0, 1, 4'b0100, 4'b0000, 4'b0011, 0, 2);
    cyc(1,  0, 4'b0000, 0, 1, 4'b1000, 4'b0000, 4'b0111, 0, 1);
    cyc(0,  1, 4'b0010, 1, 0, 4'b0000, 4'b1110, 4'b1111, 1, 0);
    cyc(0,  0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0001, 0, 3);
    // mispredict with same-cycle alloc request: grant suppressed
    cyc(1,  1, 4'b0001, 1, 0, 4'b0000, 4'b0001, 4'b0001, 0, 3);
    cyc(0,  0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4);
    // same-cycle correct resolve and grant: freed slot not reused
    cyc(1,  0, 4'b0000, 0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 4);
    cyc(1,  0, 4'b0000, 0, 1, 4'b0010, 4'b0000, 4'b0001, 0, 3);
    cyc(1,  1, 4'b0001, 0, 1, 4'b0100, 4'b0000, 4'b0011, 0, 2);
    cyc(0,  1, 4'b0010, 1, 0, 4'b0000, 4'b0110, 4'b0110, 0, 2);
    cyc(0,  0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4);
    // ignored resolves: non-busy slot, non-one-hot mask, resolve_valid low
    cyc(0,  1, 4'b0001, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4);
    cyc(1,  0, 4'b0000, 0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 4);
    cyc(1,  0, 4'b0000, 0, 1, 4'b0010, 4'b0000, 4'b0001, 0, 3);
    cyc(0,  1, 4'b0011, 1, 0, 4'b0000, 4'b0000, 4'b0011, 0, 2);
    cyc(0,  0, 4'b0001, 1, 0, 4'b0000, 4'b0000, 4'b0011, 0, 2);
    // state intact: mispredict slot 0 kills dependent slot 1
    cyc(0,  1, 4'b0001, 1, 0, 4'b0000, 4'b0011, 4'b0011, 0, 2);
    cyc(0,  0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
    end

`ifdef BRAT_ALLOC_STATS_EN
    // counters restart at the mid-run reset
    checks++;
    if (stat_stall_cycles != 32'd0) begin
      errors++; $display("FAIL stat_stall_cycles actual=%0d expected=0", stat_stall_cycles);
    end
    checks++;
    if (stat_squashes != 32'd4) begin
      errors++; $display("FAIL stat_squashes actual=%0d expected=4", stat_squashes);
    end
    checks++;
    if (stat_slots_squashed != 32'd8) begin
      errors++; $display("FAIL stat_slots_squashed actual=%0d expected=8", stat_slots_squashed);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
